// File: rtl/vm_pkg.sv
// Shared vending-machine definitions: coin codes, coin values, balance
// ceiling and the change-dispenser FSM state encoding.
package vm_pkg;

    localparam logic [1:0] COIN_NONE    = 2'b00;
    localparam logic [1:0] COIN_NICKEL  = 2'b01;
    localparam logic [1:0] COIN_DIME    = 2'b10;
    localparam logic [1:0] COIN_QUARTER = 2'b11;

    localparam int VAL_NICKEL  = 5;
    localparam int VAL_DIME    = 10;
    localparam int VAL_QUARTER = 25;

    localparam int MAX_BALANCE = 100;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SELECT = 3'd2,
        ST_EJECT  = 3'd3,
        ST_GAP    = 3'd4,
        ST_DONE   = 3'd5,
        ST_FAULT  = 3'd6
    } state_t;

endpackage

// File: rtl/change_dispenser_if.sv
// Controller/hopper side of the change dispenser. Handshake rule for coins:
// eject is the request and stays high with coin_sel stable until the hopper
// raises hopper_ack; the coin is taken on the first clock edge where both
// are high. hopper_ack while eject is low has no effect.
interface change_dispenser_if #(parameter int AMT_W = 7) ();
    import vm_pkg::*;

    logic             start;
    logic [AMT_W-1:0] amount;
    logic             hopper_ack;
    logic             busy;
    logic             done;
    logic             err;
    logic [1:0]       coin_sel;
    logic             eject;
    logic [2:0]       n_quarter;
    logic [2:0]       n_dime;
    logic [2:0]       n_nickel;
    logic             fault;
    state_t           dbg_state;

    // Controller and hopper side
    modport master (
        output start, amount, hopper_ack,
        input  busy, done, err, coin_sel, eject,
        input  n_quarter, n_dime, n_nickel, fault, dbg_state
    );

    // Dispenser side
    modport slave (
        input  start, amount, hopper_ack,
        output busy, done, err, coin_sel, eject,
        output n_quarter, n_dime, n_nickel, fault, dbg_state
    );

endinterface

// File: rtl/coin_picker.sv
// Greedy coin choice: largest coin not exceeding the remaining amount.
// Also used by the vending controller for balance display.
module coin_picker
    import vm_pkg::*;
#(
    parameter int AMT_W = 7
) (
    input  logic [AMT_W-1:0] remaining,
    output logic [1:0]       coin_sel,
    output logic [AMT_W-1:0] coin_val
);

    // Compare chain from quarter down to nickel
    always_comb begin
        coin_sel = COIN_NONE;
        coin_val = '0;
        if (remaining >= AMT_W'(VAL_QUARTER)) begin
            coin_sel = COIN_QUARTER;
            coin_val = AMT_W'(VAL_QUARTER);
        end else if (remaining >= AMT_W'(VAL_DIME)) begin
            coin_sel = COIN_DIME;
            coin_val = AMT_W'(VAL_DIME);
        end else if (remaining >= AMT_W'(VAL_NICKEL)) begin
            coin_sel = COIN_NICKEL;
            coin_val = AMT_W'(VAL_NICKEL);
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: returns an amount in quarters, dimes and nickels, one
// coin per eject/ack handshake, with a fixed idle gap between coins.
// Optional build macro HOPPER_TIMEOUT_EN adds an ack timeout that parks the
// block in FAULT until reset.
module change_dispenser
    import vm_pkg::*;
#(
    parameter int AMT_W          = 7,
    parameter int MAX_AMT        = MAX_BALANCE,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input logic               clock,
    input logic               reset,
    change_dispenser_if.slave bus
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    state_t           state;
    logic             start_q;
    logic [AMT_W-1:0] amount_q;
    logic [AMT_W-1:0] remaining;
    logic [GW-1:0]    gap_cnt;
    logic             busy_r;
    logic             done_r;
    logic             err_r;
    logic             eject_r;
    logic [1:0]       coin_sel_r;
    logic [2:0]       n_quarter_r;
    logic [2:0]       n_dime_r;
    logic [2:0]       n_nickel_r;

    logic [AMT_W-1:0] amt_clamp;
    logic [AMT_W-1:0] amt_round;
    logic             amt_err;
    logic [1:0]       pick_sel;
    logic [AMT_W-1:0] pick_val;

`ifdef HOPPER_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TW-1:0] tmo_cnt;
    logic          fault_r;
`endif

    // remaining never changes during EJECT, so pick_val is the value of the
    // coin currently being ejected
    coin_picker #(.AMT_W(AMT_W)) u_picker (
        .remaining (remaining),
        .coin_sel  (pick_sel),
        .coin_val  (pick_val)
    );

    // Clamp the latched request and round it down to a multiple of 5
    always_comb begin
        amt_clamp = (amount_q > AMT_W'(MAX_AMT)) ? AMT_W'(MAX_AMT) : amount_q;
        amt_round = amt_clamp - (amt_clamp % AMT_W'(5));
        amt_err   = (amount_q > AMT_W'(MAX_AMT)) || ((amount_q % AMT_W'(5)) != '0);
    end

    // Dispense FSM with registered outputs; start is latched for one cycle so
    // LOAD takes effect one edge after the start edge
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            start_q     <= 1'b0;
            amount_q    <= '0;
            remaining   <= '0;
            gap_cnt     <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            eject_r     <= 1'b0;
            coin_sel_r  <= COIN_NONE;
            n_quarter_r <= '0;
            n_dime_r    <= '0;
            n_nickel_r  <= '0;
`ifdef HOPPER_TIMEOUT_EN
            tmo_cnt     <= '0;
            fault_r     <= 1'b0;
`endif
        end else begin
            start_q <= 1'b0;
            done_r  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_q) begin
                        state       <= ST_LOAD;
                        remaining   <= amt_round;
                        err_r       <= amt_err;
                        n_quarter_r <= '0;
                        n_dime_r    <= '0;
                        n_nickel_r  <= '0;
                        busy_r      <= 1'b1;
                    end else if (bus.start) begin
                        start_q  <= 1'b1;
                        amount_q <= bus.amount;
                        busy_r   <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    state <= ST_SELECT;
                end
                ST_SELECT: begin
                    if (pick_sel == COIN_NONE) begin
                        state  <= ST_DONE;
                        done_r <= 1'b1;
                    end else begin
                        state      <= ST_EJECT;
                        coin_sel_r <= pick_sel;
                        eject_r    <= 1'b1;
`ifdef HOPPER_TIMEOUT_EN
                        tmo_cnt    <= '0;
`endif
                    end
                end
                ST_EJECT: begin
                    if (bus.hopper_ack) begin
                        state      <= ST_GAP;
                        eject_r    <= 1'b0;
                        coin_sel_r <= COIN_NONE;
                        remaining  <= remaining - pick_val;
                        gap_cnt    <= '0;
                        case (coin_sel_r)
                            COIN_QUARTER: n_quarter_r <= n_quarter_r + 3'd1;
                            COIN_DIME:    n_dime_r    <= n_dime_r + 3'd1;
                            COIN_NICKEL:  n_nickel_r  <= n_nickel_r + 3'd1;
                            default:      ;
                        endcase
`ifdef HOPPER_TIMEOUT_EN
                    end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        state      <= ST_FAULT;
                        eject_r    <= 1'b0;
                        coin_sel_r <= COIN_NONE;
                        fault_r    <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
`endif
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
                        state <= ST_SELECT;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    busy_r <= 1'b0;
                end
`ifdef HOPPER_TIMEOUT_EN
                ST_FAULT: begin
                    state <= ST_FAULT;
                end
`endif
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.err       = err_r;
    assign bus.eject     = eject_r;
    assign bus.coin_sel  = coin_sel_r;
    assign bus.n_quarter = n_quarter_r;
    assign bus.n_dime    = n_dime_r;
    assign bus.n_nickel  = n_nickel_r;
    assign bus.dbg_state = state;
`ifdef HOPPER_TIMEOUT_EN
    assign bus.fault     = fault_r;
`else
    assign bus.fault     = 1'b0;
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: hopper responder, pulse monitors and
// a linear sequence of transactions with hand-computed expectations.
module tb_change_dispenser;
    import vm_pkg::*;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    change_dispenser_if #(.AMT_W(7)) bus ();

    change_dispenser #(
        .AMT_W          (7),
        .MAX_AMT        (100),
        .GAP_CYCLES     (2),
        .TIMEOUT_CYCLES (20)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    int done_cnt  = 0;
    int eject_cyc = 0;

    bit         hopper_en = 1'b1;
    int         ack_delay = 2;
    int         wait_cnt  = 0;
    logic [1:0] coin_log[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Hopper: raise ack for one cycle ack_delay cycles after eject rises
    initial begin
        bus.hopper_ack = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            bus.hopper_ack = 1'b0;
            if (hopper_en && bus.eject === 1'b1) begin
                wait_cnt++;
                if (wait_cnt >= ack_delay) begin
                    bus.hopper_ack = 1'b1;
                    coin_log.push_back(bus.coin_sel);
                    wait_cnt = 0;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Pulse monitors
    always @(negedge clock) begin
        if (bus.done === 1'b1) done_cnt++;
        if (bus.eject === 1'b1) eject_cyc++;
    end

    // Watchdog
    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic start_txn(input logic [6:0] a);
        @(posedge clock);
        #1;
        bus.start  = 1'b1;
        bus.amount = a;
        @(posedge clock);
        #1;
        bus.start  = 1'b0;
        bus.amount = '0;
    endtask

    task automatic wait_done(input string tag);
        int cyc = 0;
        while (bus.done !== 1'b1 && cyc < 400) begin
            @(negedge clock);
            cyc++;
        end
        chk({tag, "_done_seen"}, 32'(bus.done), 32'd1);
    endtask

    task automatic wait_eject(input string tag);
        int cyc = 0;
        while (bus.eject !== 1'b1 && cyc < 400) begin
            @(negedge clock);
            cyc++;
        end
        chk({tag, "_eject_seen"}, 32'(bus.eject), 32'd1);
    endtask

    task automatic wait_eject_low(input string tag);
        int cyc = 0;
        while (bus.eject !== 1'b0 && cyc < 400) begin
            @(negedge clock);
            cyc++;
        end
        chk({tag, "_eject_low"}, 32'(bus.eject), 32'd0);
    endtask

    initial begin
        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.amount = '0;

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_state", 32'(bus.dbg_state), 32'(ST_IDLE));
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_eject", 32'(bus.eject), 32'd0);
        chk("rst_coin_sel", 32'(bus.coin_sel), 32'd0);
        chk("rst_nq", 32'(bus.n_quarter), 32'd0);
        chk("rst_nd", 32'(bus.n_dime), 32'd0);
        chk("rst_nn", 32'(bus.n_nickel), 32'd0);
        chk("rst_fault", 32'(bus.fault), 32'd0);
        reset = 1'b0;

        // 65 cents: Q Q D N, with cycle-exact start of the sequence
        coin_log.delete();
        done_cnt = 0;
        start_txn(7'd65);
        @(negedge clock);
        chk("a65_busy_k", 32'(bus.busy), 32'd1);
        chk("a65_eject_k", 32'(bus.eject), 32'd0);
        @(negedge clock);
        chk("a65_state_load", 32'(bus.dbg_state), 32'(ST_LOAD));
        chk("a65_err", 32'(bus.err), 32'd0);
        @(negedge clock);
        chk("a65_state_select", 32'(bus.dbg_state), 32'(ST_SELECT));
        chk("a65_eject_k2", 32'(bus.eject), 32'd0);
        @(negedge clock);
        chk("a65_eject_k3", 32'(bus.eject), 32'd1);
        chk("a65_sel_k3", 32'(bus.coin_sel), 32'(COIN_QUARTER));
        wait_done("a65");
        chk("a65_nq", 32'(bus.n_quarter), 32'd2);
        chk("a65_nd", 32'(bus.n_dime), 32'd1);
        chk("a65_nn", 32'(bus.n_nickel), 32'd1);
        chk("a65_err_end", 32'(bus.err), 32'd0);
        chk("a65_busy_done", 32'(bus.busy), 32'd1);
        repeat (10) @(negedge clock);
        chk("a65_done_cnt", 32'(done_cnt), 32'd1);
        chk("a65_busy_after", 32'(bus.busy), 32'd0);
        chk("a65_coins", 32'(coin_log.size()), 32'd4);
        if (coin_log.size() == 4) begin
            chk("a65_coin0", 32'(coin_log[0]), 32'(COIN_QUARTER));
            chk("a65_coin1", 32'(coin_log[1]), 32'(COIN_QUARTER));
            chk("a65_coin2", 32'(coin_log[2]), 32'(COIN_DIME));
            chk("a65_coin3", 32'(coin_log[3]), 32'(COIN_NICKEL));
        end

        // 0 cents: done in the cycle after edge k+3, no eject
        eject_cyc = 0;
        done_cnt  = 0;
        start_txn(7'd0);
        @(negedge clock);
        chk("a0_done_k", 32'(bus.done), 32'd0);
        @(negedge clock);
        chk("a0_done_k1", 32'(bus.done), 32'd0);
        @(negedge clock);
        chk("a0_done_k2", 32'(bus.done), 32'd0);
        @(negedge clock);
        chk("a0_done_k3", 32'(bus.done), 32'd1);
        chk("a0_nq", 32'(bus.n_quarter), 32'd0);
        chk("a0_nd", 32'(bus.n_dime), 32'd0);
        chk("a0_nn", 32'(bus.n_nickel), 32'd0);
        chk("a0_err", 32'(bus.err), 32'd0);
        @(negedge clock);
        chk("a0_done_k4", 32'(bus.done), 32'd0);
        chk("a0_busy_k4", 32'(bus.busy), 32'd0);
        chk("a0_eject_cyc", 32'(eject_cyc), 32'd0);

        // 127 cents clamps to 100: four quarters
        coin_log.delete();
        start_txn(7'd127);
        wait_done("a127");
        chk("a127_nq", 32'(bus.n_quarter), 32'd4);
        chk("a127_nd", 32'(bus.n_dime), 32'd0);
        chk("a127_nn", 32'(bus.n_nickel), 32'd0);
        chk("a127_err", 32'(bus.err), 32'd1);
        chk("a127_coins", 32'(coin_log.size()), 32'd4);

        // 37 cents rounds to 35: quarter then dime
        coin_log.delete();
        start_txn(7'd37);
        wait_done("a37");
        chk("a37_nq", 32'(bus.n_quarter), 32'd1);
        chk("a37_nd", 32'(bus.n_dime), 32'd1);
        chk("a37_nn", 32'(bus.n_nickel), 32'd0);
        chk("a37_err", 32'(bus.err), 32'd1);
        chk("a37_coins", 32'(coin_log.size()), 32'd2);
        if (coin_log.size() == 2) begin
            chk("a37_coin0", 32'(coin_log[0]), 32'(COIN_QUARTER));
            chk("a37_coin1", 32'(coin_log[1]), 32'(COIN_DIME));
        end

        // Start of 50 while busy dispensing 30 is ignored
        repeat (3) @(negedge clock);
        coin_log.delete();
        done_cnt = 0;
        start_txn(7'd30);
        wait_eject("busy30");
        bus.start  = 1'b1;
        bus.amount = 7'd50;
        @(posedge clock);
        #1;
        bus.start  = 1'b0;
        bus.amount = '0;
        wait_done("busy30");
        chk("busy30_nq", 32'(bus.n_quarter), 32'd1);
        chk("busy30_nd", 32'(bus.n_dime), 32'd0);
        chk("busy30_nn", 32'(bus.n_nickel), 32'd1);
        repeat (20) @(negedge clock);
        chk("busy30_done_cnt", 32'(done_cnt), 32'd1);
        chk("busy30_coins", 32'(coin_log.size()), 32'd2);
        chk("busy30_state", 32'(bus.dbg_state), 32'(ST_IDLE));

        // Reset while the second quarter of 65 is being ejected
        start_txn(7'd65);
        wait_eject("rst65_first");
        wait_eject_low("rst65_first");
        wait_eject("rst65_second");
        chk("rst65_nq_pre", 32'(bus.n_quarter), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("rst65_eject", 32'(bus.eject), 32'd0);
        chk("rst65_busy", 32'(bus.busy), 32'd0);
        chk("rst65_nq", 32'(bus.n_quarter), 32'd0);
        chk("rst65_sel", 32'(bus.coin_sel), 32'd0);
        chk("rst65_state", 32'(bus.dbg_state), 32'(ST_IDLE));
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        coin_log.delete();
        done_cnt = 0;
        start_txn(7'd10);
        wait_done("a10");
        chk("a10_nq", 32'(bus.n_quarter), 32'd0);
        chk("a10_nd", 32'(bus.n_dime), 32'd1);
        chk("a10_nn", 32'(bus.n_nickel), 32'd0);
        chk("a10_err", 32'(bus.err), 32'd0);
        repeat (5) @(negedge clock);
        chk("a10_done_cnt", 32'(done_cnt), 32'd1);
        chk("a10_coins", 32'(coin_log.size()), 32'd1);
        if (coin_log.size() == 1) begin
            chk("a10_coin0", 32'(coin_log[0]), 32'(COIN_DIME));
        end
        chk("a10_fault", 32'(bus.fault), 32'd0);

`ifdef HOPPER_TIMEOUT_EN
        // Hopper never acks: fault after 20 EJECT cycles, cleared by reset
        hopper_en = 1'b0;
        done_cnt  = 0;
        start_txn(7'd5);
        wait_eject("tmo");
        repeat (19) @(negedge clock);
        chk("tmo_fault_19", 32'(bus.fault), 32'd0);
        chk("tmo_eject_19", 32'(bus.eject), 32'd1);
        @(negedge clock);
        chk("tmo_fault_20", 32'(bus.fault), 32'd1);
        chk("tmo_eject_20", 32'(bus.eject), 32'd0);
        chk("tmo_busy_20", 32'(bus.busy), 32'd1);
        chk("tmo_state", 32'(bus.dbg_state), 32'(ST_FAULT));
        repeat (5) @(negedge clock);
        chk("tmo_hold", 32'(bus.fault), 32'd1);
        chk("tmo_no_done", 32'(done_cnt), 32'd0);
        reset = 1'b1;
        #1;
        chk("tmo_rst_fault", 32'(bus.fault), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        hopper_en = 1'b1;
`endif

        repeat (3) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
